// File: rtl/ad7606_pkg.sv
// Shared constants and types for the AD7606 boxcar decimator.
// Optional build macro: AD7606_DEC_ROUND_EN (round half up before the final shift).
package ad7606_pkg;

  // Channels per frame, sample width and channel index width.
  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int CHW = $clog2(NCH);

  // Accumulator width needed to sum 2^dec_log2 signed samples without overflow.
  function automatic int acc_width(input int dec_log2);
    return DW + dec_log2;
  endfunction

  // One sample as it travels from the accumulator stage into the output bank.
  typedef struct packed {
    logic [CHW-1:0] chan;
    logic [DW-1:0]  data;
  } sample_t;

  // Output stream state: idle, or presenting the eight beats of a frame.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ob_state_e;

endpackage

// File: rtl/ad7606_dec_outbuf.sv
// Output buffer of the AD7606 decimator: holds one averaged frame and streams
// it as NCH valid/ready beats. Busy from the moment the last channel of a
// committed window lands until the beat carrying m_last is accepted.
module ad7606_dec_outbuf
  import ad7606_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  sample_t        wr_smp,
  output logic           out_busy,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DW-1:0]  m_data,
  output logic [CHW-1:0] m_chan,
  output logic           m_last
);

  ob_state_e      state_q, state_d;
  logic [CHW-1:0] idx_q, idx_d;
  logic [DW-1:0]  bank_q [NCH];
  logic [DW-1:0]  bank_d [NCH];
  logic           last_idx;

  assign last_idx = (idx_q == CHW'(NCH - 1));

  // Result bank write port: one channel per committed sample.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[wr_smp.chan] = wr_smp.data;
    end
  end

  // Result bank storage.
  always_ff @(posedge clk) begin
    // NOTE: the bank is not reset; it is only read in SEND, after a full window has overwritten it.
    bank_q <= bank_d;
  end

  // Next state: start sending when the last channel is written, step on each handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (wr_en && (wr_smp.chan == CHW'(NCH - 1))) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (last_idx) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Stream outputs: forced to zero outside SEND, held while the beat is stalled.
  always_comb begin
    m_valid  = (state_q == SEND);
    out_busy = (state_q == SEND);
    m_data   = '0;
    m_chan   = '0;
    m_last   = 1'b0;
    if (state_q == SEND) begin
      m_data = bank_q[idx_q];
      m_chan = idx_q;
      m_last = last_idx;
    end
  end

endmodule

// File: rtl/ad7606_decimator.sv
// AD7606 boxcar decimator: averages 2^DEC_LOG2 consecutive 8-channel frames
// and emits one averaged frame as an 8-beat valid/ready stream. The input has
// no backpressure; out-of-order channels and windows that arrive while the
// output is still busy are flagged instead.
// Optional build macro: AD7606_DEC_ROUND_EN adds 2^(DEC_LOG2-1) before the
// final arithmetic shift (round half up); without it the result is floored.
module ad7606_decimator
  import ad7606_pkg::*;
#(
  parameter int DEC_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  input  logic [CHW-1:0] s_chan,
  input  logic [DW-1:0]  s_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DW-1:0]  m_data,
  output logic [CHW-1:0] m_chan,
  output logic           m_last,
  input  logic           sts_clr,
  output logic           err_seq,
  output logic           overrun,
  output logic [7:0]     ovr_cnt
);

  localparam int AW  = acc_width(DEC_LOG2);
  localparam int FCW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [FCW-1:0] FR_LAST = FCW'((1 << DEC_LOG2) - 1);
`ifdef AD7606_DEC_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'((1 << DEC_LOG2) >> 1);
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  // Sequencer and status state.
  logic [CHW-1:0]       exp_chan_q, exp_chan_d;
  logic [FCW-1:0]       frame_cnt_q, frame_cnt_d;
  logic                 commit_q, commit_d;
  logic                 err_seq_q, err_seq_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           ovr_cnt_q, ovr_cnt_d;
  logic signed [AW-1:0] acc_q [NCH];
  logic signed [AW-1:0] acc_d [NCH];

  // Per-sample decode.
  logic                 accept;
  logic                 seq_err;
  logic                 first_frame;
  logic                 final_frame;
  logic                 decide;
  logic                 commit_now;
  logic                 ovr_now;
  logic signed [AW-1:0] smp_ext;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] sum;

  // Output bank interface.
  logic                 wr_en;
  sample_t              wr_smp;
  logic                 out_busy;

  // Datapath: accept check, running sum and the averaged result for the bank.
  always_comb begin
    accept      = s_valid && (s_chan == exp_chan_q);
    seq_err     = s_valid && !accept;
    first_frame = (frame_cnt_q == '0);
    final_frame = (frame_cnt_q == FR_LAST);
    // The keep/discard decision for a window is taken once, at chan 0 of its last frame.
    decide      = accept && final_frame && (s_chan == '0);
    commit_now  = decide ? !out_busy : commit_q;
    ovr_now     = decide && out_busy;
    smp_ext     = AW'(signed'(s_data));
    acc_base    = acc_q[s_chan];
    if (first_frame) begin
      acc_base = '0;
    end
    sum         = acc_base + smp_ext;
    wr_en       = accept && final_frame && commit_now;
    wr_smp.chan = s_chan;
    wr_smp.data = DW'((sum + RND) >>> DEC_LOG2);
  end

  // Sequencer: expected channel, frame position in the window, accumulators.
  always_comb begin
    exp_chan_d  = exp_chan_q;
    frame_cnt_d = frame_cnt_q;
    commit_d    = commit_q;
    acc_d       = acc_q;
    if (accept) begin
      acc_d[s_chan] = sum;
      if (decide) begin
        commit_d = !out_busy;
      end
      if (exp_chan_q == CHW'(NCH - 1)) begin
        exp_chan_d  = '0;
        frame_cnt_d = final_frame ? '0 : frame_cnt_q + 1'b1;
      end else begin
        exp_chan_d = exp_chan_q + 1'b1;
      end
    end else if (seq_err) begin
      // Drop the sample and restart the window from a clean frame 0.
      exp_chan_d  = '0;
      frame_cnt_d = '0;
      commit_d    = 1'b0;
    end
  end

  // Sticky status: a new event in the same cycle as sts_clr keeps the flag set.
  always_comb begin
    err_seq_d = seq_err ? 1'b1 : (sts_clr ? 1'b0 : err_seq_q);
    overrun_d = ovr_now ? 1'b1 : (sts_clr ? 1'b0 : overrun_q);
    ovr_cnt_d = sts_clr ? 8'd0 : ovr_cnt_q;
    if (ovr_now && (ovr_cnt_d != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_d + 8'd1;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_chan_q  <= '0;
      frame_cnt_q <= '0;
      commit_q    <= 1'b0;
      err_seq_q   <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= 8'd0;
    end else begin
      exp_chan_q  <= exp_chan_d;
      frame_cnt_q <= frame_cnt_d;
      commit_q    <= commit_d;
      err_seq_q   <= err_seq_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  // Accumulators: frame 0 of every window reloads them, so they need no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign err_seq = err_seq_q;
  assign overrun = overrun_q;
  assign ovr_cnt = ovr_cnt_q;

  ad7606_dec_outbuf u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_smp   (wr_smp),
    .out_busy (out_busy),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .m_last   (m_last)
  );

endmodule

// File: doc/ad7606_decimator.md
Name: ad7606_decimator

Overview:
- Downstream stage of the AD7606 parallel-read controller. It consumes the per-channel 16-bit samples the controller reads after each conversion (CH1..CH8, one frame per conversion).
- Averages 2^DEC_LOG2 consecutive frames per channel (boxcar decimation) and emits one averaged frame as an 8-beat valid/ready stream toward the DMA/packetiser.
- Flags sequencing errors and output overruns. The ADC side cannot be stalled, so the input has no backpressure.

Parameters:
- NCH, 8, channels per frame; CHW = $clog2(NCH).
- DW, 16, sample width; two's complement, matching the AD7606 ±10 V range coding.
- DEC_LOG2, 4, log2 of frames averaged per output; legal 0..8; 0 = pass-through.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  one-cycle pulse, sample present
- s_chan  in  CHW  channel index of sample, 0 = CH1
- s_data  in  DW  signed sample
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DW  averaged signed sample
- m_chan  out  CHW  channel of beat
- m_last  out  1  high on beat with m_chan = NCH-1
- sts_clr  in  1  clears err_seq, overrun, ovr_cnt
- err_seq  out  1  sticky: out-of-order channel seen
- overrun  out  1  sticky: window discarded, output busy
- ovr_cnt  out  8  saturating count of discarded windows

Behaviour:
- Reset: all outputs 0; exp_chan=0, frame_cnt=0, out_busy=0; accumulators are don't-care because frame 0 loads them.
- Accumulator: per channel, width DW+DEC_LOG2, sign-extended.
  - Frame 0 of a window loads the sample.
  - Later frames add the sample.
- Input sequencing:
  - s_valid with s_chan == exp_chan: accept; exp_chan increments and wraps at NCH-1.
  - On chan NCH-1: frame_cnt increments, wrapping at 2^DEC_LOG2-1.
  - s_valid with s_chan != exp_chan: sample dropped; err_seq=1; exp_chan=0; frame_cnt=0 (window restarts).
- Final frame (frame_cnt == 2^DEC_LOG2-1):
  - Commit decision is made at its chan-0 sample.
  - If out_busy=0: each accepted sample writes result[c] = (acc+sext(sample)) >>> DEC_LOG2, arithmetic shift, into the output bank.
  - If out_busy=1: window discarded; overrun=1; ovr_cnt+1, saturating at 255.
  - out_busy freeing later in the same frame does not rescue that window.
- Output handover: committed chan NCH-1 written at cycle T → out_busy=1, m_valid=1 at T+1 with m_chan=0. Latency is 1 cycle.
- Output FSM:
  - States: IDLE → SEND → IDLE.
  - In SEND, m_data/m_chan/m_last are held stable while m_valid && !m_ready.
  - Each handshake advances the index.
  - Handshake with m_last → IDLE, m_valid=0, out_busy=0 on the next cycle.
- Width: the mean of DW-bit values always fits in DW bits; no saturation logic.
- Simultaneous events:
  - An input sample and an output handshake in the same cycle are independent.
  - sts_clr coincident with a new error: the error wins (flag stays 1).
- rst mid-operation: within one cycle m_valid=0, flags cleared, partial window abandoned.

Optional Feature:
- Macro AD7606_DEC_ROUND_EN.
- Defined: add 2^(DEC_LOG2-1) before the shift (round half up); no effect when DEC_LOG2=0.
- Undefined: plain arithmetic shift (floor).
- Result range is unchanged either way.

Decomposition:
- Package ad7606_pkg holds:
  - NCH, DW, CHW constants
  - an accumulator-width function
  - a sample struct {chan, data}
  - the output FSM state enum (IDLE, SEND)
- Sub-module ad7606_dec_outbuf: NCH×DW result bank, out_busy flag, and the valid/ready SEND FSM. The top module keeps the accumulators, sequencer and status logic.

Test Plan:
- DEC_LOG2=2; 4 ordered frames, chan c = 100·c → 8 beats with m_data 0,100..700 and m_last on chan 7; m_valid rises 1 cycle after the final chan-7 sample.
- DEC_LOG2=2; chan 0 fed -3,-2,-2,-2 (sum -9) → m_data -3 without the macro, -2 with AD7606_DEC_ROUND_EN.
- m_ready held 0 through a full second window → first frame's data held stable; overrun=1, ovr_cnt=1; after release, 8 beats of window 1 only.
- Chans 0,1,3 → err_seq=1; the next 4 correct frames of value 50 → all beats 50; sts_clr → err_seq=0.
- DEC_LOG2=0 → every frame is output unchanged, e.g. chan 5 = -32768 gives m_data -32768.
- rst asserted during SEND beat 3 → m_valid=0 next cycle; a fresh 4-frame window afterwards produces a correct output.
